// File: rtl/idct_recon_pkg.sv
// Types shared by IDCT_1D, the dequantiser and the reconstruction stage.
package idct_pkg;

  localparam int COEF_W = 16;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    DONE
  } recon_state_t;

endpackage

// File: rtl/idct_recon_sample.sv
// Combinational round/shift, prediction add and clip for one reconstructed sample.
module idct_recon_sample
  import idct_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int SHIFT     = 0
) (
  input  coef_t                y,
  input  logic [BIT_DEPTH-1:0] pred,
  output logic [BIT_DEPTH-1:0] pixel,
  output logic                 clipped
);

  localparam logic signed [17:0] PIX_MAX = 18'((2 ** BIT_DEPTH) - 1);

  logic signed [16:0] r;
  logic signed [17:0] s;

  generate
    if (SHIFT > 0) begin : g_round
      // Round half up, then arithmetic shift: floor((y + 2^(SHIFT-1)) / 2^SHIFT).
      assign r = (17'(y) + 17'(2 ** (SHIFT - 1))) >>> SHIFT;
    end else begin : g_pass
      assign r = 17'(y);
    end
  endgenerate

  assign s = 18'(r) + $signed(18'(pred));

  always_comb begin
    clipped = 1'b0;
    pixel   = s[BIT_DEPTH-1:0];
    if (s < 0) begin
      clipped = 1'b1;
      pixel   = '0;
    end else if (s > PIX_MAX) begin
      clipped = 1'b1;
      pixel   = '1;
    end
  end

endmodule

// File: rtl/idct_recon.sv
// Reconstruction stage: snapshots a residual/prediction block and writes one clipped row per cycle.
module idct_recon
  import idct_pkg::*;
#(
  parameter int N         = 4,
  parameter int BIT_DEPTH = 8,
  parameter int SHIFT     = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  coef_t [N-1:0][N-1:0]                 y,
  input  logic  [N-1:0][N-1:0][BIT_DEPTH-1:0]  pred,
  output logic  [N-1:0][N-1:0][BIT_DEPTH-1:0]  rec,
  output logic                                 busy,
  output logic                                 done,
  output logic  [$clog2(N*N+1)-1:0]            clip_count
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N * N + 1);

  recon_state_t state, state_next;

  logic [RW-1:0]                          row_cnt;
  logic                                   last_row;
  coef_t [N-1:0][N-1:0]                   y_q;
  logic  [N-1:0][N-1:0][BIT_DEPTH-1:0]    pred_q;
  logic  [CW-1:0]                         clip_run;

  logic [N-1:0][BIT_DEPTH-1:0] row_pix;
  logic [N-1:0]                row_clip;
  logic [CW-1:0]               row_clips;

  assign last_row = (row_cnt == RW'(N - 1));

  generate
    for (genvar c = 0; c < N; c++) begin : g_col
      idct_recon_sample #(
        .BIT_DEPTH (BIT_DEPTH),
        .SHIFT     (SHIFT)
      ) u_sample (
        .y       (y_q[row_cnt][c]),
        .pred    (pred_q[row_cnt][c]),
        .pixel   (row_pix[c]),
        .clipped (row_clip[c])
      );
    end
  endgenerate

  always_comb begin
    row_clips = '0;
    for (int unsigned c = 0; c < N; c++) begin
      row_clips = row_clips + CW'(row_clip[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = PROC;
      PROC:    if (last_row) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt    <= '0;
      y_q        <= '0;
      pred_q     <= '0;
      rec        <= '0;
      clip_run   <= '0;
      clip_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            y_q      <= y;
            pred_q   <= pred;
            row_cnt  <= '0;
            clip_run <= '0;
          end
        end
        PROC: begin
          rec[row_cnt] <= row_pix;
          row_cnt      <= row_cnt + RW'(1);
          clip_run     <= clip_run + row_clips;
          // Publish the block total together with the final row write.
          if (last_row) begin
            clip_count <= clip_run + row_clips;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_recon.sv
// Randomized and directed checks of idct_recon (SHIFT=0 and SHIFT=2) against an integer reference model.
module tb_idct_recon;
  import idct_pkg::*;

  localparam int N  = 4;
  localparam int BD = 8;
  localparam int CW = $clog2(N * N + 1);

  logic clk = 1'b0;
  logic reset;
  logic start;
  coef_t [N-1:0][N-1:0]          y;
  logic  [N-1:0][N-1:0][BD-1:0]  pred;

  logic [N-1:0][N-1:0][BD-1:0] rec0, rec2;
  logic busy0, busy2, done0, done2;
  logic [CW-1:0] cc0, cc2;

  int ty[N][N];
  int tp[N][N];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  idct_recon #(.N(N), .BIT_DEPTH(BD), .SHIFT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .y(y), .pred(pred),
    .rec(rec0), .busy(busy0), .done(done0), .clip_count(cc0)
  );

  idct_recon #(.N(N), .BIT_DEPTH(BD), .SHIFT(2)) dut_s2 (
    .clk(clk), .reset(reset), .start(start), .y(y), .pred(pred),
    .rec(rec2), .busy(busy2), .done(done2), .clip_count(cc2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: rounding right shift by exact floor division, add, clamp to pixel range.
  function automatic int model_pix(input int yv, input int pv, input int shift, output bit clipped);
    int r, s, d;
    r = yv;
    if (shift > 0) begin
      d = 1 << shift;
      r = yv + d / 2;
      r = (r >= 0) ? (r / d) : -((-r + d - 1) / d);
    end
    s = r + pv;
    clipped = 1'b0;
    if (s < 0) begin
      clipped = 1'b1;
      return 0;
    end
    if (s > (1 << BD) - 1) begin
      clipped = 1'b1;
      return (1 << BD) - 1;
    end
    return s;
  endfunction

  task automatic apply_inputs();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        y[r][c]    = 16'(ty[r][c]);
        pred[r][c] = BD'(tp[r][c]);
      end
  endtask

  task automatic scramble_inputs();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        y[r][c]    = 16'($urandom);
        pred[r][c] = BD'($urandom);
      end
  endtask

  task automatic fill(input int yv, input int pv);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ty[r][c] = yv;
        tp[r][c] = pv;
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ty[r][c] = int'($urandom_range(0, 1400)) - 700;
        tp[r][c] = int'($urandom_range(0, 255));
      end
  endtask

  task automatic check_zero_state(input string tag);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        check($sformatf("%s rec0[%0d][%0d]", tag, r, c), int'(rec0[r][c]), 0);
        check($sformatf("%s rec2[%0d][%0d]", tag, r, c), int'(rec2[r][c]), 0);
      end
    check({tag, " busy0"}, int'(busy0), 0);
    check({tag, " done0"}, int'(done0), 0);
    check({tag, " clip0"}, int'(cc0), 0);
    check({tag, " busy2"}, int'(busy2), 0);
    check({tag, " done2"}, int'(done2), 0);
    check({tag, " clip2"}, int'(cc2), 0);
  endtask

  // Runs one block from ty/tp; inputs are scrambled right after the start edge.
  task automatic run_block(input string tag, input bit repulse);
    int edges, busy_n, done_n, exp0, exp2, cnt0, cnt2;
    bit seen, cl;
    apply_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    busy_n = int'(busy0);
    done_n = 0;
    edges  = 0;
    seen   = 1'b0;
    while (!seen && edges < 4 * N) begin
      start = (repulse && (edges == 1 || edges == 2));
      @(posedge clk); #1;
      edges++;
      if (busy0) busy_n++;
      if (done0) begin
        seen = 1'b1;
        done_n++;
        check({tag, " done2 aligned"}, int'(done2), 1);
      end
    end
    start = 1'b0;
    check({tag, " done latency"}, seen ? edges : -1, N);
    cnt0 = 0;
    cnt2 = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        exp0 = model_pix(ty[r][c], tp[r][c], 0, cl);
        cnt0 += int'(cl);
        exp2 = model_pix(ty[r][c], tp[r][c], 2, cl);
        cnt2 += int'(cl);
        check($sformatf("%s rec0[%0d][%0d]", tag, r, c), int'(rec0[r][c]), exp0);
        check($sformatf("%s rec2[%0d][%0d]", tag, r, c), int'(rec2[r][c]), exp2);
      end
    check({tag, " clip0"}, int'(cc0), cnt0);
    check({tag, " clip2"}, int'(cc2), cnt2);
    @(posedge clk); #1;
    if (done0) done_n++;
    check({tag, " done pulses"}, done_n, 1);
    check({tag, " busy cycles"}, busy_n, N + 1);
    check({tag, " idle busy"}, int'(busy0), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill(0, 0);
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_zero_state("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    fill(0, 128);
    run_block("flat", 1'b0);
    check("flat rec0 value", int'(rec0[2][3]), 128);

    fill(200, 100);
    run_block("sat_hi", 1'b0);
    check("sat_hi clip total", int'(cc0), 16);

    fill(-300, 50);
    run_block("sat_lo", 1'b0);
    check("sat_lo clip total", int'(cc0), 16);

    fill(0, 0);
    ty[0][0] = 1000;
    run_block("dc", 1'b0);
    check("dc rec0[0][0]", int'(rec0[0][0]), 255);
    check("dc clip total", int'(cc0), 1);

    fill_random();
    run_block("snap", 1'b1);

    // Reset while PROC is about to write row 2.
    fill_random();
    apply_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero_state("midreset");
    reset = 1'b0;
    fill_random();
    run_block("post_reset", 1'b0);

    fill_random();
    ty[0][0] = -5;    tp[0][0] = 10;
    ty[0][1] = 6;     tp[0][1] = 10;
    ty[0][2] = -1000; tp[0][2] = 0;
    run_block("shift2", 1'b0);
    check("shift2 y=-5", int'(rec2[0][0]), 9);
    check("shift2 y=6", int'(rec2[0][1]), 12);
    check("shift2 y=-1000", int'(rec2[0][2]), 0);

    for (int i = 0; i < 12; i++) begin
      fill_random();
      run_block($sformatf("rand%0d", i), $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
